// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

    localparam int ITERS = 32;

    localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the sign of finished results.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Negate when asked, otherwise pass the value straight through.
    always_comb begin
        result = negate ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a
// single sign-fix cycle that writes HI/LO and pulses done.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITERS = mdu_pkg::ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t               state;
    state_t               state_next;
    op_t                  op_q;
    logic                 sign_a;
    logic                 sign_b;
    logic                 dbz_pending;
    logic [WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        counter;

    logic                 capture;
    logic                 capture_dbz;
    logic                 run_step;
    logic                 finish;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   div_next;

    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    assign capture_dbz = op[1] && (src_b == '0);

    mdu_sign_fix #(.W(WIDTH)) abs_a (
        .value  (src_a),
        .negate (op[0] && src_a[WIDTH-1]),
        .result (mag_a)
    );

    mdu_sign_fix #(.W(WIDTH)) abs_b (
        .value  (src_b),
        .negate (op[0] && src_b[WIDTH-1]),
        .result (mag_b)
    );

    mdu_sign_fix #(.W(2*WIDTH)) fix_prod (
        .value  (acc),
        .negate ((op_q == OP_MULT) && (sign_a ^ sign_b)),
        .result (prod_fixed)
    );

    mdu_sign_fix #(.W(WIDTH)) fix_quo (
        .value  (acc[WIDTH-1:0]),
        .negate ((op_q == OP_DIV) && (sign_a ^ sign_b)),
        .result (quo_fixed)
    );

    mdu_sign_fix #(.W(WIDTH)) fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate ((op_q == OP_DIV) && sign_a),
        .result (rem_fixed)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: divide by zero skips the iteration phase entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = capture_dbz ? S_FIX : S_RUN;
            S_RUN:   if (counter == LAST) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        busy     = (state != S_IDLE);
        capture  = (state == S_IDLE) && start;
        run_step = (state == S_RUN);
        finish   = (state == S_FIX);
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, addend});
        div_diff  = div_shift[WIDTH-1:0] - addend;
        rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {rem_next, acc[WIDTH-2:0], div_ge};
    end

    // Operand capture and the iterating accumulator/counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_MULTU;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dbz_pending <= 1'b0;
            addend      <= '0;
            acc         <= '0;
            counter     <= '0;
        end else if (capture) begin
            op_q        <= op_t'(op);
            sign_a      <= src_a[WIDTH-1];
            sign_b      <= src_b[WIDTH-1];
            dbz_pending <= capture_dbz;
            counter     <= '0;
            if (op[1]) begin
                addend <= mag_b;
                acc    <= capture_dbz ? {src_a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, mag_a};
            end else begin
                addend <= mag_a;
                acc    <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (run_step) begin
            acc     <= op_q[1] ? div_next : mul_next;
            counter <= counter + 1'b1;
        end
    end

    // Architectural HI/LO, done pulse and sticky divide-by-zero flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finish) begin
                done <= 1'b1;
                if (dbz_pending) begin
                    hi          <= acc[2*WIDTH-1:WIDTH];
                    lo          <= DBZ_LO;
                    div_by_zero <= 1'b1;
                end else if (op_q[1]) begin
                    hi <= rem_fixed;
                    lo <= quo_fixed;
                end else begin
                    {hi, lo} <= prod_fixed;
                end
            end else if (capture) begin
                div_by_zero <= 1'b0;
            end else if (state == S_IDLE) begin
                if (mthi) hi <= wr_data;
                if (mtlo) lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a transaction-level model
// computes each result with plain integer arithmetic and a countdown,
// and a compare process checks every output on every falling edge.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dbz = 1'b0;
    int          m_left = 0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic        p_dbz = 1'b0;

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of one operation using plain integer arithmetic
    function automatic void computeResult(input logic [1:0] f_op, input logic [31:0] a,
                                          input logic [31:0] b, output logic [31:0] r_hi,
                                          output logic [31:0] r_lo, output logic r_dbz);
        longint          sa;
        longint          sb;
        longint          sp;
        longint          q;
        longint          r;
        longint unsigned up;
        r_dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r_hi = '0;
        r_lo = '0;
        case (f_op)
            2'b00: begin
                up = {32'b0, a} * {32'b0, b};
                {r_hi, r_lo} = up;
            end
            2'b01: begin
                sp = sa * sb;
                {r_hi, r_lo} = sp;
            end
            default: begin
                if (b == 32'd0) begin
                    r_dbz = 1'b1;
                    r_hi  = a;
                    r_lo  = 32'hFFFF_FFFF;
                end else if (f_op == 2'b10) begin
                    r_lo = a / b;
                    r_hi = a % b;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    r_lo = q[31:0];
                    r_hi = r[31:0];
                end
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: accepts a start when idle, finishes after a fixed delay
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0;
            m_lo = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    if (p_dbz) m_dbz = 1'b1;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                computeResult(op, src_a, src_b, p_hi, p_lo, p_dbz);
                m_dbz = 1'b0;
                m_busy = 1'b1;
                m_left = p_dbz ? 1 : 33;
            end else begin
                if (mthi) m_hi = wr_data;
                if (mtlo) m_lo = wr_data;
            end
        end
    end

    // Compare every output against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
        checkOutput("hi", hi, m_hi);
        checkOutput("lo", lo, m_lo);
    end

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Launch one operation, feed ignored junk while busy, wait for done
    task automatic applyStimulus(input logic [1:0] t_op, input logic [31:0] a,
                                 input logic [31:0] b, input logic with_mthi,
                                 input logic lit_en, input logic [31:0] lit_hi,
                                 input logic [31:0] lit_lo, input logic lit_dbz,
                                 input int exp_lat);
        int cycles;
        start   = 1'b1;
        op      = t_op;
        src_a   = a;
        src_b   = b;
        mthi    = with_mthi;
        mtlo    = 1'b0;
        wr_data = $urandom;
        @(negedge clk);
        cycles = 0;
        while (!done && cycles < 100) begin
            start   = (cycles < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
            op      = 2'($urandom_range(0, 3));
            src_a   = $urandom;
            src_b   = $urandom;
            mthi    = 1'($urandom_range(0, 1));
            mtlo    = 1'($urandom_range(0, 1));
            wr_data = $urandom;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        if (lit_en) begin
            checkOutput("lit_hi", hi, lit_hi);
            checkOutput("lit_lo", lo, lit_lo);
            checkOutput("lit_dbz", {31'b0, div_by_zero}, {31'b0, lit_dbz});
        end
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        #1 reset = 1'b1;
        @(negedge clk);

        mthi = 1'b1;
        wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        checkOutput("mthi_hi", hi, 32'hA5A5_A5A5);
        mtlo = 1'b1;
        wr_data = 32'h5A5A_0000;
        @(negedge clk);
        mtlo = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h5A5A_0000);

        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
        applyStimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
        applyStimulus(2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
        applyStimulus(2'b10, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, 1'b0, 33);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 33);
        applyStimulus(2'b10, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
        applyStimulus(2'b00, 32'd3, 32'd5, 1'b1, 1'b1, 32'h0, 32'd15, 1'b0, 33);

        // Reset ten cycles into an operation
        start = 1'b1;
        op = 2'b00;
        src_a = $urandom;
        src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
        checkOutput("midrst_hi", hi, 32'h0);
        checkOutput("midrst_lo", lo, 32'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("midrst_done", {31'b0, done}, 32'h0);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        applyStimulus(2'b10, 32'd1000, 32'd10, 1'b0, 1'b1, 32'd0, 32'd100, 1'b0, 33);

        // Randomized operations with idle-time MTHI/MTLO traffic
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pickVal();
            r_b  = ($urandom_range(0, 7) == 0) ? 32'h0 : pickVal();
            applyStimulus(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 32'h0, 1'b0,
                          (r_op[1] && r_b == 32'h0) ? 1 : 33);
            repeat ($urandom_range(0, 2)) begin
                mthi    = 1'($urandom_range(0, 1));
                mtlo    = 1'($urandom_range(0, 1));
                wr_data = $urandom;
                @(negedge clk);
            end
            mthi = 1'b0;
            mtlo = 1'b0;
        end

        @(posedge clk);
        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
